chroma_interp_fir: RTL and testbench



---
 rtl/chroma_interp_fir_if.sv | 21 ++
 rtl/chroma_interp_fir.sv | 178 +++++++++++++++++
 tb/tb_chroma_interp_fir.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/chroma_interp_fir_if.sv
// Streaming handshake bundle between the U/V fetch path, the chroma upsampler and the CSC stage.
interface chroma_interp_fir_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_even;
  logic [7:0] out_odd;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_even, out_odd, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_even, out_odd, out_last, out_valid
  );
endinterface

// File: rtl/chroma_interp_fir.sv
// Horizontal 2x chroma upsampler: even = U[j], odd = 6-tap half-pel FIR with edge replication.
// Define CHROMA_INTERP_STATS_EN to add the sat_count port (count of clamped odd outputs).
//
// state   | meaning
// S_IDLE  | waiting for U[0]; loads t0..t3 with it
// S_FILL  | collecting U[1..3]; U[3] produces pair 0
// S_RUN   | each accepted sample steps the taps and emits one pair
// S_FLUSH | input blocked; replicate last sample to emit the final 3 pairs
module chroma_interp_fir #(
  parameter int ROW_SAMPLES = 160,
  parameter int ROUND       = 128
) (
  input  logic                CLOCK_50_I,
  input  logic                resetn,
  chroma_interp_fir_if.slave  bus
`ifdef CHROMA_INTERP_STATS_EN
  ,
  output logic [15:0]         sat_count
`endif
);

  localparam logic [9:0] LAST_IDX = 10'(ROW_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [7:0]        tap_q [6];
  logic [7:0]        tap_d [6];
  logic [9:0]        in_cnt_q, in_cnt_d;
  logic [9:0]        out_cnt_q, out_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [7:0]        out_even_q, out_even_d;
  logic [7:0]        out_odd_q, out_odd_d;

  logic              slot_free, in_ready, accept, step;
  logic [7:0]        win [6];
  logic signed [19:0] acc, sh;
  logic [7:0]        odd_clamp;

  assign slot_free = ~out_valid_q | bus.out_ready;
  assign accept    = bus.in_valid & in_ready;

  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FILL;
      S_FILL, S_RUN: begin
        if (accept && in_cnt_q == LAST_IDX) state_d = S_FLUSH;
        else if (step)                      state_d = S_RUN;
      end
      S_FLUSH: if (slot_free && out_cnt_q == LAST_IDX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // U[1], U[2] only fill taps, so the output slot need not be free for them.
  always_comb begin
    in_ready = 1'b0;
    step     = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = slot_free;
      S_FILL: begin
        in_ready = (in_cnt_q == 10'd3) ? slot_free : 1'b1;
        step     = accept && (in_cnt_q == 10'd3);
      end
      S_RUN: begin
        in_ready = slot_free;
        step     = accept;
      end
      S_FLUSH: step = slot_free;
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 5; i++) win[i] = tap_q[i+1];
    win[5] = (state_q == S_FLUSH) ? tap_q[5] : bus.in_data;
  end

  function automatic logic signed [19:0] ext(input logic [7:0] s);
    return $signed({12'd0, s});
  endfunction

  always_comb begin
    acc = 20'sd21  * (ext(win[0]) + ext(win[5]))
        - 20'sd52  * (ext(win[1]) + ext(win[4]))
        + 20'sd159 * (ext(win[2]) + ext(win[3]))
        + 20'(ROUND);
    sh = acc >>> 8;
    if (sh < 20'sd0)        odd_clamp = 8'd0;
    else if (sh > 20'sd255) odd_clamp = 8'd255;
    else                    odd_clamp = sh[7:0];
  end

  always_comb begin
    tap_d       = tap_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_even_d  = out_even_q;
    out_odd_d   = out_odd_q;

    if (accept) in_cnt_d = (in_cnt_q == LAST_IDX) ? 10'd0 : in_cnt_q + 10'd1;

    if (state_q == S_IDLE && accept) begin
      for (int i = 0; i < 4; i++) tap_d[i] = bus.in_data;
    end else if (state_q == S_FILL && accept && in_cnt_q == 10'd1) begin
      tap_d[4] = bus.in_data;
    end else if (state_q == S_FILL && accept && in_cnt_q == 10'd2) begin
      tap_d[5] = bus.in_data;
    end

    // A new pair may load in the same cycle the old one retires.
    if (step) begin
      tap_d       = win;
      out_valid_d = 1'b1;
      out_even_d  = win[2];
      out_odd_d   = odd_clamp;
      out_last_d  = (out_cnt_q == LAST_IDX);
      out_cnt_d   = (out_cnt_q == LAST_IDX) ? 10'd0 : out_cnt_q + 10'd1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      for (int i = 0; i < 6; i++) tap_q[i] <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_even_q  <= '0;
      out_odd_q   <= '0;
    end else begin
      tap_q       <= tap_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_even_q  <= out_even_d;
      out_odd_q   <= out_odd_d;
    end
  end

`ifdef CHROMA_INTERP_STATS_EN
  logic        sat;
  logic [15:0] sat_q, sat_d;

  assign sat = (sh < 20'sd0) || (sh > 20'sd255);

  always_comb begin
    sat_d = sat_q;
    if (step && sat && sat_q != 16'hFFFF) sat_d = sat_q + 16'd1;
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) sat_q <= '0;
    else         sat_q <= sat_d;
  end

  assign sat_count = sat_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_even  = out_even_q;
  assign bus.out_odd   = out_odd_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_chroma_interp_fir.sv
// Directed bench for chroma_interp_fir: flat, edge, impulse, step, stalled ramp and mid-row reset rows.
module tb_chroma_interp_fir;
  localparam int N = 160;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #10 clk = ~clk;

  chroma_interp_fir_if bus_if();
`ifdef CHROMA_INTERP_STATS_EN
  logic [15:0] sat_count;
`endif

  chroma_interp_fir #(.ROW_SAMPLES(N), .ROUND(128)) dut (
    .CLOCK_50_I (clk),
    .resetn     (resetn),
    .bus        (bus_if)
`ifdef CHROMA_INTERP_STATS_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int row [N];
  int cap_even [$];
  int cap_odd  [$];
  int cap_last [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int smp(input int k);
    if (k < 0) k = 0;
    if (k > N - 1) k = N - 1;
    return row[k];
  endfunction

  function automatic int model_odd(input int j);
    int s;
    s = 21 * smp(j-2) - 52 * smp(j-1) + 159 * smp(j) + 159 * smp(j+1)
      - 52 * smp(j+2) + 21 * smp(j+3) + 128;
    s = s >>> 8;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic do_reset(input string name);
    @(negedge clk);
    resetn = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'd0;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk({name, " out_valid"}, 32'(bus_if.out_valid), 0);
    chk({name, " out_even"},  32'(bus_if.out_even),  0);
    chk({name, " out_odd"},   32'(bus_if.out_odd),   0);
    chk({name, " out_last"},  32'(bus_if.out_last),  0);
    chk({name, " in_ready"},  32'(bus_if.in_ready),  1);
`ifdef CHROMA_INTERP_STATS_EN
    chk({name, " sat_count"}, 32'(sat_count), 0);
`endif
  endtask

  // Feeds row[] and collects pairs; rnd randomises in_valid and out_ready.
  task automatic run_row(input string name, input bit rnd, input int stop_pairs);
    int idx = 0;
    int cyc = 0;
    int acc4_cyc = -1;
    bit got_last = 1'b0;
    bit hold = 1'b0;
    logic [7:0] he, ho;
    logic hl;
    logic ov_at_acc4 = 1'b0;
    int hold_err = 0;
    int flush_err = 0;
    cap_even.delete();
    cap_odd.delete();
    cap_last.delete();
    while (!got_last && cap_even.size() < stop_pairs && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        if (bus_if.out_valid !== 1'b1 || bus_if.out_even !== he ||
            bus_if.out_odd !== ho || bus_if.out_last !== hl) hold_err++;
      end
      if (!rnd && acc4_cyc >= 0 && cyc == acc4_cyc + 1) begin
        chk({name, " latency pre"},  32'(ov_at_acc4), 0);
        chk({name, " latency post"}, 32'(bus_if.out_valid), 1);
      end
      bus_if.in_valid  = (idx < N) && (!rnd || $urandom_range(0, 1) == 1);
      bus_if.in_data   = (idx < N) ? 8'(row[idx]) : 8'd0;
      bus_if.out_ready = !rnd || ($urandom_range(0, 1) == 1);
      #1;
      if (idx == N && !(bus_if.out_valid && bus_if.out_last) && bus_if.in_ready) flush_err++;
      hold = bus_if.out_valid && !bus_if.out_ready;
      he = bus_if.out_even;
      ho = bus_if.out_odd;
      hl = bus_if.out_last;
      if (bus_if.out_valid && bus_if.out_ready) begin
        cap_even.push_back(int'(bus_if.out_even));
        cap_odd.push_back(int'(bus_if.out_odd));
        cap_last.push_back(int'(bus_if.out_last));
        if (bus_if.out_last) got_last = 1'b1;
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        idx++;
        if (idx == 4) begin
          acc4_cyc = cyc;
          ov_at_acc4 = bus_if.out_valid;
        end
      end
    end
    @(posedge clk);
    #1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    chk({name, " completed"}, 32'(got_last || cap_even.size() >= stop_pairs), 1);
    chk({name, " hold stable"}, 32'(hold_err), 0);
    chk({name, " in_ready in flush"}, 32'(flush_err), 0);
    if (stop_pairs >= N) begin
      chk({name, " pair count"}, 32'(cap_even.size()), N);
      for (int j = 0; j < cap_even.size() && j < N; j++) begin
        chk($sformatf("%s even[%0d]", name, j), 32'(cap_even[j]), 32'(row[j]));
        chk($sformatf("%s odd[%0d]",  name, j), 32'(cap_odd[j]),  32'(model_odd(j)));
        chk($sformatf("%s last[%0d]", name, j), 32'(cap_last[j]), 32'(j == N - 1));
      end
    end
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'd0;
    bus_if.out_ready = 1'b0;
    do_reset("rst0");

    for (int j = 0; j < N; j++) row[j] = 100;
    run_row("flat", 1'b0, N);

    for (int j = 0; j < N; j++) row[j] = 0;
    row[0] = 200;
    run_row("ledge", 1'b0, N);
    if (cap_odd.size() == N) begin
      chk("ledge odd0", 32'(cap_odd[0]), 100);
      chk("ledge odd1", 32'(cap_odd[1]), 0);
      chk("ledge odd2", 32'(cap_odd[2]), 16);
    end
`ifdef CHROMA_INTERP_STATS_EN
    chk("ledge sat_count", 32'(sat_count), 1);
`endif

    do_reset("rst1");
    for (int j = 0; j < N; j++) row[j] = 0;
    row[10] = 255;
    run_row("impulse", 1'b0, N);
    if (cap_odd.size() == N) begin
      chk("impulse odd7",  32'(cap_odd[7]),  21);
      chk("impulse odd8",  32'(cap_odd[8]),  0);
      chk("impulse odd9",  32'(cap_odd[9]),  158);
      chk("impulse odd10", 32'(cap_odd[10]), 158);
      chk("impulse odd11", 32'(cap_odd[11]), 0);
      chk("impulse odd12", 32'(cap_odd[12]), 21);
    end
`ifdef CHROMA_INTERP_STATS_EN
    chk("impulse sat_count", 32'(sat_count), 2);
`endif

    for (int j = 0; j < N; j++) row[j] = (j < 80) ? 0 : 255;
    run_row("step", 1'b0, N);
    if (cap_odd.size() == N) begin
      chk("step odd78",  32'(cap_odd[78]),  0);
      chk("step odd79",  32'(cap_odd[79]),  128);
      chk("step odd80",  32'(cap_odd[80]),  255);
      chk("step odd81",  32'(cap_odd[81]),  234);
      chk("step odd82",  32'(cap_odd[82]),  255);
      chk("step even80", 32'(cap_even[80]), 255);
    end

    for (int j = 0; j < N; j++) row[j] = j;
    run_row("ramp", 1'b1, N);

    for (int j = 0; j < N; j++) row[j] = 100;
    run_row("partial", 1'b0, 51);
    do_reset("rst_mid");
    for (int j = 0; j < N; j++) row[j] = 7;
    run_row("flat7", 1'b0, N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
